// File: rtl/handshake_traffic_gen.sv
// handshake_traffic_gen
//   Valid/ready packet source. A start request in IDLE latches the pattern
//   mode, seed and packet length, then the block offers pkt_len beats to the
//   post-stage. The data pattern is either an incrementing count or a
//   Fibonacci LFSR sequence. stall_i lets the source skip offering a beat.
//
// Ports
//   clk, rst_n    clock and synchronous active-low reset
//   start_i       request one packet (honoured only in IDLE with pkt_len_i != 0)
//   mode_i        0 = increment pattern, 1 = LFSR pattern
//   seed_i        data value of the first beat
//   pkt_len_i     number of beats in the packet
//   stall_i       1 = do not offer a new beat on this free edge
//   ready_i       post-stage can accept the current beat
//   valid_o       beat on data_o/last_o is valid (registered)
//   data_o        beat data, 0 whenever valid_o is 0
//   last_o        final beat of the packet
//   busy_o        packet in progress
//   sent_cnt_o    saturating count of handshakes since reset
module handshake_traffic_gen #(
  parameter int                DATA_W    = 8,
  parameter int                LEN_W     = 8,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic [LEN_W-1:0]  pkt_len_i,
  input  logic              stall_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  sent_cnt_o
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [LEN_W-1:0]  ONE_L = LEN_W'(1);
  localparam logic [DATA_W-1:0] ONE_D = DATA_W'(1);
  localparam logic [CNT_W-1:0]  ONE_C = CNT_W'(1);

  // Pattern step applied after each offered beat.
  function automatic logic [DATA_W-1:0] next_pat(input logic m,
                                                 input logic [DATA_W-1:0] p);
    if (m) return {p[DATA_W-2:0], ^(p & LFSR_TAPS)};
    else   return p + ONE_D;
  endfunction

  // An all-zero LFSR state would lock up, so a zero seed becomes 1.
  function automatic logic [DATA_W-1:0] fix_seed(input logic m,
                                                 input logic [DATA_W-1:0] s);
    if (m && (s == '0)) return ONE_D;
    else                return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == '1) return c;
    else         return c + ONE_C;
  endfunction

  state_t            state, state_d;
  logic              mode_q, mode_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_cnt, beat_d;   // beats already offered
  logic [DATA_W-1:0] pat_q, pat_d;       // data of the next beat to offer
  logic              valid_d, last_d;
  logic [DATA_W-1:0] data_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [DATA_W-1:0] seed_eff;
  logic              hs, free;

  assign hs     = valid_o & ready_i;
  assign free   = ~valid_o | hs;
  assign busy_o = (state == SEND);

  always_comb begin
    state_d  = state;
    mode_d   = mode_q;
    len_d    = len_q;
    beat_d   = beat_cnt;
    pat_d    = pat_q;
    valid_d  = valid_o;
    data_d   = data_o;
    last_d   = last_o;
    cnt_d    = sent_cnt_o;
    seed_eff = fix_seed(mode_i, seed_i);

    case (state)
      IDLE: begin
        if (start_i && (pkt_len_i != '0)) begin
          state_d = SEND;
          mode_d  = mode_i;
          len_d   = pkt_len_i;
          // The accepting edge is already a free edge for the first beat.
          if (!stall_i) begin
            valid_d = 1'b1;
            data_d  = seed_eff;
            last_d  = (pkt_len_i == ONE_L);
            beat_d  = ONE_L;
            pat_d   = next_pat(mode_i, seed_eff);
          end else begin
            valid_d = 1'b0;
            data_d  = '0;
            last_d  = 1'b0;
            beat_d  = '0;
            pat_d   = seed_eff;
          end
        end
      end
      SEND: begin
        if (hs && last_o) begin
          state_d = IDLE;
          valid_d = 1'b0;
          data_d  = '0;
          last_d  = 1'b0;
        end else if (free) begin
          if ((beat_cnt != len_q) && !stall_i) begin
            valid_d = 1'b1;
            data_d  = pat_q;
            last_d  = ((beat_cnt + ONE_L) == len_q);
            beat_d  = beat_cnt + ONE_L;
            pat_d   = next_pat(mode_q, pat_q);
          end else begin
            valid_d = 1'b0;
            data_d  = '0;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (hs) cnt_d = sat_inc(sent_cnt_o);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      len_q      <= '0;
      beat_cnt   <= '0;
      pat_q      <= '0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      last_o     <= 1'b0;
      sent_cnt_o <= '0;
    end else begin
      state      <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      beat_cnt   <= beat_d;
      pat_q      <= pat_d;
      valid_o    <= valid_d;
      data_o     <= data_d;
      last_o     <= last_d;
      sent_cnt_o <= cnt_d;
    end
  end

endmodule

// File: tb/tb_handshake_traffic_gen.sv
// Directed bench for handshake_traffic_gen: increment and LFSR patterns,
// backpressure hold, stall gaps with wrap, ignored starts, mid-packet reset.
module tb_handshake_traffic_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        mode_i;
  logic [7:0]  seed_i;
  logic [7:0]  pkt_len_i;
  logic        stall_i;
  logic        ready_i;
  logic        valid_o;
  logic [7:0]  data_o;
  logic        last_o;
  logic        busy_o;
  logic [15:0] sent_cnt_o;

  int total = 0;
  int bad   = 0;

  handshake_traffic_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .seed_i     (seed_i),
    .pkt_len_i  (pkt_len_i),
    .stall_i    (stall_i),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .last_o     (last_o),
    .busy_o     (busy_o),
    .sent_cnt_o (sent_cnt_o)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {valid, data, last, busy}
  task automatic test_reset();
    logic [10:0] act, exp;
    rst_n = 1'b0; start_i = 1'b0; mode_i = 1'b0; seed_i = 8'h00;
    pkt_len_i = 8'd0; stall_i = 1'b0; ready_i = 1'b1;
    step(); step();
    act = {valid_o, data_o, last_o, busy_o}; exp = 11'h000; total++;
    if (act !== exp) begin bad++; $display("FAIL reset_out act=%h exp=%h", act, exp); end
    total++;
    if (sent_cnt_o !== 16'd0) begin bad++; $display("FAIL reset_cnt act=%0d exp=0", sent_cnt_o); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_increment();
    logic [10:0] act, exp;
    logic [7:0]  expd [4] = '{8'h05, 8'h06, 8'h07, 8'h08};
    start_i = 1'b1; mode_i = 1'b0; seed_i = 8'h05; pkt_len_i = 8'd4;
    ready_i = 1'b1; stall_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      start_i = 1'b0;
      act = {valid_o, data_o, last_o, busy_o};
      exp = {1'b1, expd[i], (i == 3), 1'b1}; total++;
      if (act !== exp) begin bad++; $display("FAIL inc_beat%0d act=%h exp=%h", i, act, exp); end
    end
    step();
    act = {valid_o, data_o, last_o, busy_o}; exp = 11'h000; total++;
    if (act !== exp) begin bad++; $display("FAIL inc_end act=%h exp=%h", act, exp); end
    total++;
    if (sent_cnt_o !== 16'd4) begin bad++; $display("FAIL inc_cnt act=%0d exp=4", sent_cnt_o); end
  endtask

  task automatic test_backpressure();
    logic [10:0] act, exp;
    start_i = 1'b1; mode_i = 1'b0; seed_i = 8'h10; pkt_len_i = 8'd2;
    ready_i = 1'b0; stall_i = 1'b0;
    step();
    start_i = 1'b0;
    act = {valid_o, data_o, last_o, busy_o}; exp = {1'b1, 8'h10, 1'b0, 1'b1}; total++;
    if (act !== exp) begin bad++; $display("FAIL bp_first act=%h exp=%h", act, exp); end
    for (int i = 0; i < 3; i++) begin
      stall_i = ~stall_i;
      step();
      act = {valid_o, data_o, last_o, busy_o}; total++;
      if (act !== exp) begin bad++; $display("FAIL bp_hold%0d act=%h exp=%h", i, act, exp); end
    end
    total++;
    if (sent_cnt_o !== 16'd4) begin bad++; $display("FAIL bp_cnt_hold act=%0d exp=4", sent_cnt_o); end
    ready_i = 1'b1; stall_i = 1'b0;
    step();
    act = {valid_o, data_o, last_o, busy_o}; exp = {1'b1, 8'h11, 1'b1, 1'b1}; total++;
    if (act !== exp) begin bad++; $display("FAIL bp_second act=%h exp=%h", act, exp); end
    step();
    act = {valid_o, data_o, last_o, busy_o}; exp = 11'h000; total++;
    if (act !== exp) begin bad++; $display("FAIL bp_end act=%h exp=%h", act, exp); end
    total++;
    if (sent_cnt_o !== 16'd6) begin bad++; $display("FAIL bp_cnt act=%0d exp=6", sent_cnt_o); end
  endtask

  task automatic test_wrap_stall();
    logic [10:0] act, exp;
    // per edge: stall value applied, expected {valid,data,last,busy}
    logic        stl  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [10:0] expv [6] = '{{1'b1, 8'hFE, 1'b0, 1'b1},
                              {1'b0, 8'h00, 1'b0, 1'b1},
                              {1'b0, 8'h00, 1'b0, 1'b1},
                              {1'b1, 8'hFF, 1'b0, 1'b1},
                              {1'b1, 8'h00, 1'b1, 1'b1},
                              11'h000};
    start_i = 1'b1; mode_i = 1'b0; seed_i = 8'hFE; pkt_len_i = 8'd3;
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      stall_i = stl[i];
      step();
      start_i = 1'b0;
      act = {valid_o, data_o, last_o, busy_o}; exp = expv[i]; total++;
      if (act !== exp) begin bad++; $display("FAIL wrap_edge%0d act=%h exp=%h", i, act, exp); end
    end
    stall_i = 1'b0;
    total++;
    if (sent_cnt_o !== 16'd9) begin bad++; $display("FAIL wrap_cnt act=%0d exp=9", sent_cnt_o); end
  endtask

  task automatic test_lfsr();
    logic [10:0] act, exp;
    logic [7:0]  expd [3] = '{8'h01, 8'h02, 8'h04};
    logic [7:0]  expd2 [2] = '{8'h81, 8'h03};
    start_i = 1'b1; mode_i = 1'b1; seed_i = 8'h00; pkt_len_i = 8'd3;
    ready_i = 1'b1; stall_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      start_i = 1'b0; mode_i = 1'b0;
      act = {valid_o, data_o, last_o, busy_o};
      exp = {1'b1, expd[i], (i == 2), 1'b1}; total++;
      if (act !== exp) begin bad++; $display("FAIL lfsr0_beat%0d act=%h exp=%h", i, act, exp); end
    end
    step();
    start_i = 1'b1; mode_i = 1'b1; seed_i = 8'h81; pkt_len_i = 8'd2;
    for (int i = 0; i < 2; i++) begin
      step();
      start_i = 1'b0; mode_i = 1'b0;
      act = {valid_o, data_o, last_o, busy_o};
      exp = {1'b1, expd2[i], (i == 1), 1'b1}; total++;
      if (act !== exp) begin bad++; $display("FAIL lfsr81_beat%0d act=%h exp=%h", i, act, exp); end
    end
    step();
    total++;
    if (sent_cnt_o !== 16'd14) begin bad++; $display("FAIL lfsr_cnt act=%0d exp=14", sent_cnt_o); end
  endtask

  task automatic test_ignored_starts();
    logic [10:0] act, exp;
    start_i = 1'b1; mode_i = 1'b0; seed_i = 8'h55; pkt_len_i = 8'd0;
    ready_i = 1'b1; stall_i = 1'b0;
    step();
    start_i = 1'b0;
    act = {valid_o, data_o, last_o, busy_o}; exp = 11'h000; total++;
    if (act !== exp) begin bad++; $display("FAIL len0_ignored act=%h exp=%h", act, exp); end
    // 2-beat packet with a competing start held during SEND
    start_i = 1'b1; seed_i = 8'h40; pkt_len_i = 8'd2;
    step();
    seed_i = 8'h90; pkt_len_i = 8'd5;
    act = {valid_o, data_o, last_o, busy_o}; exp = {1'b1, 8'h40, 1'b0, 1'b1}; total++;
    if (act !== exp) begin bad++; $display("FAIL send_start_b1 act=%h exp=%h", act, exp); end
    step();
    start_i = 1'b0;
    act = {valid_o, data_o, last_o, busy_o}; exp = {1'b1, 8'h41, 1'b1, 1'b1}; total++;
    if (act !== exp) begin bad++; $display("FAIL send_start_b2 act=%h exp=%h", act, exp); end
    step();
    act = {valid_o, data_o, last_o, busy_o}; exp = 11'h000; total++;
    if (act !== exp) begin bad++; $display("FAIL send_start_end act=%h exp=%h", act, exp); end
    // single-beat packet
    start_i = 1'b1; seed_i = 8'h33; pkt_len_i = 8'd1;
    step();
    start_i = 1'b0;
    act = {valid_o, data_o, last_o, busy_o}; exp = {1'b1, 8'h33, 1'b1, 1'b1}; total++;
    if (act !== exp) begin bad++; $display("FAIL one_beat act=%h exp=%h", act, exp); end
    step();
    act = {valid_o, data_o, last_o, busy_o}; exp = 11'h000; total++;
    if (act !== exp) begin bad++; $display("FAIL one_beat_end act=%h exp=%h", act, exp); end
    total++;
    if (sent_cnt_o !== 16'd17) begin bad++; $display("FAIL ignored_cnt act=%0d exp=17", sent_cnt_o); end
  endtask

  task automatic test_mid_reset();
    logic [10:0] act, exp;
    start_i = 1'b1; mode_i = 1'b0; seed_i = 8'h20; pkt_len_i = 8'd5;
    ready_i = 1'b1; stall_i = 1'b0;
    step();
    start_i = 1'b0;
    step();
    act = {valid_o, data_o, last_o, busy_o}; exp = {1'b1, 8'h21, 1'b0, 1'b1}; total++;
    if (act !== exp) begin bad++; $display("FAIL mid_beat2 act=%h exp=%h", act, exp); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    act = {valid_o, data_o, last_o, busy_o}; exp = 11'h000; total++;
    if (act !== exp) begin bad++; $display("FAIL mid_rst_out act=%h exp=%h", act, exp); end
    total++;
    if (sent_cnt_o !== 16'd0) begin bad++; $display("FAIL mid_rst_cnt act=%0d exp=0", sent_cnt_o); end
    for (int i = 0; i < 4; i++) begin
      step();
      act = {valid_o, data_o, last_o, busy_o}; total++;
      if (act !== exp) begin bad++; $display("FAIL mid_after%0d act=%h exp=%h", i, act, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_backpressure();
    test_wrap_stall();
    test_lfsr();
    test_ignored_starts();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/handshake_traffic_gen.md
HANDSHAKE_TRAFFIC_GEN -- requirements
Module: handshake_traffic_gen

Parameters
REQ-001 Parameter DATA_W, default 8: width of data_o, seed_i and the pattern register.
REQ-002 Parameter LEN_W, default 8: width of pkt_len_i and of the beat counter.
REQ-003 Parameter LFSR_TAPS, default 8'hB8: Fibonacci feedback mask for LFSR mode, DATA_W bits wide.
REQ-004 Parameter CNT_W, default 16: width of sent_cnt_o.

Interface
REQ-005 clk  input  1  single clock; all logic is rising-edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 start_i  input  1  request to send one packet; sampled only in IDLE.
REQ-008 mode_i  input  1  pattern select: 0 = increment, 1 = LFSR; sampled with start_i.
REQ-009 seed_i  input  DATA_W  first data value; sampled with start_i.
REQ-010 pkt_len_i  input  LEN_W  number of beats in the packet; sampled with start_i.
REQ-011 stall_i  input  1  source-side stall (random stall injection); 1 = do not offer a new beat.
REQ-012 ready_i  input  1  from post-stage.
REQ-013 valid_o  output  1  to post-stage; registered.
REQ-014 data_o  output  DATA_W  to post-stage; registered.
REQ-015 last_o  output  1  marks the final beat of a packet; qualified by valid_o.
REQ-016 busy_o  output  1  high while state is SEND.
REQ-017 sent_cnt_o  output  CNT_W  total handshakes since reset.

Function
REQ-018 The FSM SHALL have two states, IDLE and SEND; the reset state is IDLE.
REQ-019 In IDLE, if start_i=1 and pkt_len_i!=0, the block SHALL latch mode_i, seed_i and pkt_len_i and enter SEND on the same edge.
  - start_i with pkt_len_i=0 is ignored.
  - start_i during SEND is ignored.
REQ-020 A handshake SHALL occur on each edge where valid_o=1 and ready_i=1.
REQ-021 The block is "free" on an edge when valid_o=0 or a handshake occurs; on a free edge with at least one beat still to offer, valid_o SHALL load ~stall_i.
  - The accepting start edge counts as free, so the first beat can appear one cycle after start_i.
REQ-022 Once valid_o=1, valid_o, data_o and last_o SHALL be held stable until the handshake; stall_i is ignored while a beat is pending.
REQ-023 data_o SHALL be 0 whenever valid_o=0.
REQ-024 The first beat's data SHALL be the latched seed. In LFSR mode a latched seed of 0 is replaced by 1.
REQ-025 After each handshake the next beat's data SHALL be:
  - increment mode: previous + 1, modulo 2^DATA_W (0xFF wraps to 0x00 at DATA_W=8);
  - LFSR mode: {prev[DATA_W-2:0], ^(prev & LFSR_TAPS)}.
REQ-026 last_o SHALL be 1 exactly on the beat numbered pkt_len_i (counting from 1), including a 1-beat packet.
REQ-027 On the handshake of the last beat, the block SHALL return to IDLE with valid_o=0 on the next cycle; a new start_i is accepted from that IDLE cycle onward.
REQ-028 sent_cnt_o SHALL increment by 1 per handshake and saturate at 2^CNT_W-1.
REQ-029 busy_o SHALL equal (state==SEND).

Reset
REQ-030 While rst_n=0 at a rising edge, the block SHALL reset to:
  - state IDLE;
  - valid_o=0, data_o=0, last_o=0, busy_o=0, sent_cnt_o=0;
  - beat counter and pattern register cleared.
REQ-031 A reset asserted mid-packet SHALL abort the packet; no beat is resumed after rst_n returns to 1.

Verification
REQ-032 Increment, no backpressure: seed=0x05, len=4, mode=0, ready=1, stall=0 -> data 05,06,07,08 on consecutive cycles, last_o only with 08, sent_cnt_o=4, busy_o drops after.
REQ-033 Backpressure hold: ready=0 for 3 cycles while valid_o=1 with data 0x10, stall_i toggling -> valid_o, data_o=0x10 and last_o unchanged for all 3 cycles; handshake on ready=1.
REQ-034 Wrap plus stall: seed=0xFE, len=3, stall=1 on free cycles 2 and 3 -> data FE,FF,00 with gaps where stalled and data_o=0 in the gaps.
REQ-035 LFSR zero seed: mode=1, seed=0x00, len=3, TAPS=0xB8 -> data 01,02,04.
REQ-036 Ignored starts: start with len=0 -> busy_o stays 0; start during SEND -> packet length unchanged; 1-beat packet -> last_o on its only beat.
REQ-037 Mid-packet reset: rst_n=0 for 1 cycle after beat 2 of 5 -> all outputs 0, sent_cnt_o=0, no further beats without a new start_i.
